// File: rtl/wasm_instr_loader_pkg.sv
// Shared definitions for the WASM instruction-memory loader.
// Holds the instruction-memory geometry constants that the core also uses
// (write window width, window size log2, BRAM depth and its log2) and the
// loader state encoding, so the core and the loader cannot drift apart.
package wasm_instr_loader_pkg;

  localparam int INSTR_WRITE_WIDTH     = 64;    // bits per write window
  localparam int LOG_WRITE_WINDOW_SIZE = 3;     // log2(bytes per window)
  localparam int INSTR_BRAM_DEPTH      = 1024;  // instruction memory bytes
  localparam int INSTR_LOG2_BRAM_DEPTH = 10;    // log2(INSTR_BRAM_DEPTH)

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_t;

endpackage

// File: rtl/wasm_instr_loader_packer.sv
// instr_byte_packer: little-endian byte-lane register for one write window.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clear          empties every lane and rewinds the fill index
//   wr_en, wr_byte store wr_byte into the lane at the current fill index
//   wr_data        packed window, lane 0 in bits [7:0]; unwritten lanes are 0
//   last_lane      index of the most recently written lane (valid bytes - 1)
//   lane_full      the current fill index is the final lane of the window
module instr_byte_packer #(
  parameter int WIN_BYTES = 8,
  parameter int LOG_WIN   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [7:0]             wr_byte,
  output logic [8*WIN_BYTES-1:0] wr_data,
  output logic [LOG_WIN-1:0]     last_lane,
  output logic                   lane_full
);

  logic [LOG_WIN-1:0] fill_idx_reg;
  logic [LOG_WIN-1:0] last_lane_reg;
  logic [7:0]         lane_reg [WIN_BYTES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_idx_reg  <= '0;
      last_lane_reg <= '0;
    end else if (clear) begin
      fill_idx_reg  <= '0;
      last_lane_reg <= '0;
    end else if (wr_en) begin
      // Wraps to 0 after the final lane; the window is cleared on transfer anyway.
      fill_idx_reg  <= fill_idx_reg + LOG_WIN'(1);
      last_lane_reg <= fill_idx_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < WIN_BYTES; gi++) begin : g_lane
      // Lanes are only written forward from a cleared window, so any lane
      // beyond the fill index still reads as zero when the window is sent.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lane_reg[gi] <= '0;
        end else if (clear) begin
          lane_reg[gi] <= '0;
        end else if (wr_en && (fill_idx_reg == LOG_WIN'(gi))) begin
          lane_reg[gi] <= wr_byte;
        end
      end
      assign wr_data[gi*8 +: 8] = lane_reg[gi];
    end
  endgenerate

  assign last_lane = last_lane_reg;
  assign lane_full = (fill_idx_reg == LOG_WIN'(WIN_BYTES - 1));

endmodule

// File: rtl/wasm_instr_loader.sv
// wasm_instr_loader: streams a host byte image into the WASM core's
// instruction memory, one little-endian write window at a time, and keeps
// the core in reset until the whole image has been written.
// Ports:
//   i_clk, i_rst                     clock, asynchronous active-high reset
//   i_start                          begin a new load (IDLE/DONE/ERROR only)
//   i_byte, i_byte_vld, i_byte_last  host byte stream; last marks image end
//   o_byte_rdy                       byte accepted when i_byte_vld & o_byte_rdy
//   o_we, o_wr_data                  instruction-memory write request/window
//   o_write_pointer_shift_minusone   valid bytes in the window minus one
//   i_wr_rdy                         memory accepts the write this cycle
//   o_core_rst                       reset to the core, low only once loaded
//   o_load_done, o_load_error        image written / capacity overflow
//   o_byte_count                     bytes accepted during this load
module wasm_instr_loader
  import wasm_instr_loader_pkg::*;
#(
  parameter int WIN_BYTES   = INSTR_WRITE_WIDTH / 8,
  parameter int LOG_WIN     = LOG_WRITE_WINDOW_SIZE,
  parameter int DEPTH_BYTES = INSTR_BRAM_DEPTH,
  parameter int LOG_DEPTH   = INSTR_LOG2_BRAM_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [7:0]             i_byte,
  input  logic                   i_byte_vld,
  input  logic                   i_byte_last,
  output logic                   o_byte_rdy,
  output logic                   o_we,
  output logic [8*WIN_BYTES-1:0] o_wr_data,
  output logic [LOG_WIN-1:0]     o_write_pointer_shift_minusone,
  input  logic                   i_wr_rdy,
  output logic                   o_core_rst,
  output logic                   o_load_done,
  output logic                   o_load_error,
  output logic [LOG_DEPTH:0]     o_byte_count
);

  loader_state_t      state_reg, state_next;
  logic [LOG_DEPTH:0] count_reg;
  logic               last_seen_reg;
  logic               we_reg, done_reg, error_reg, core_rst_reg;
  logic               accept, pack_clear, count_clear;
  logic               count_full, lane_full;

  // Once the memory is full no further byte may be taken; the offer itself
  // is what triggers the overflow abort below.
  assign count_full = (count_reg == (LOG_DEPTH + 1)'(DEPTH_BYTES));
  assign o_byte_rdy = (state_reg == ST_FILL) && !count_full;
  assign accept     = o_byte_rdy && i_byte_vld;

  always_comb begin
    state_next  = state_reg;
    pack_clear  = 1'b0;
    count_clear = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          state_next  = ST_FILL;
          pack_clear  = 1'b1;
          count_clear = 1'b1;
        end
      end
      ST_FILL: begin
        if (i_byte_vld && count_full) begin
          // Overflow: drop whatever partial window exists, never write it.
          state_next = ST_ERROR;
          pack_clear = 1'b1;
        end else if (accept && (lane_full || i_byte_last)) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (i_wr_rdy) begin
          pack_clear = 1'b1;
          state_next = last_seen_reg ? ST_DONE : ST_FILL;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state register itself (o_we rises on the edge that fills a window).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= ST_IDLE;
      count_reg     <= '0;
      last_seen_reg <= 1'b0;
      we_reg        <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
      core_rst_reg  <= 1'b1;
    end else begin
      state_reg    <= state_next;
      we_reg       <= (state_next == ST_WRITE);
      done_reg     <= (state_next == ST_DONE);
      error_reg    <= (state_next == ST_ERROR);
      core_rst_reg <= (state_next != ST_DONE);
      // Accept is blocked at capacity, so the count saturates without wrapping.
      if (count_clear) begin
        count_reg <= '0;
      end else if (accept) begin
        count_reg <= count_reg + (LOG_DEPTH + 1)'(1);
      end
      if (pack_clear) begin
        last_seen_reg <= 1'b0;
      end else if (accept && i_byte_last) begin
        last_seen_reg <= 1'b1;
      end
    end
  end

  instr_byte_packer #(
    .WIN_BYTES (WIN_BYTES),
    .LOG_WIN   (LOG_WIN)
  ) u_packer (
    .clk       (i_clk),
    .rst       (i_rst),
    .clear     (pack_clear),
    .wr_en     (accept),
    .wr_byte   (i_byte),
    .wr_data   (o_wr_data),
    .last_lane (o_write_pointer_shift_minusone),
    .lane_full (lane_full)
  );

  assign o_we         = we_reg;
  assign o_load_done  = done_reg;
  assign o_load_error = error_reg;
  assign o_core_rst   = core_rst_reg;
  assign o_byte_count = count_reg;

endmodule

// File: tb/tb_wasm_instr_loader.sv
// Testbench for wasm_instr_loader (built with a 16-byte memory so that
// overflow is reachable). Images are split into expected write windows by a
// reference model; a monitor compares every memory transfer against them.
module tb_wasm_instr_loader;

  localparam int WIN   = 8;
  localparam int LOGW  = 3;
  localparam int DEPTH = 16;
  localparam int LOGD  = 4;

  typedef struct {
    logic [8*WIN-1:0] data;
    logic [LOGW-1:0]  shift;
    bit               last;
  } wr_t;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_start;
  logic [7:0]       i_byte;
  logic             i_byte_vld;
  logic             i_byte_last;
  logic             o_byte_rdy;
  logic             o_we;
  logic [8*WIN-1:0] o_wr_data;
  logic [LOGW-1:0]  o_write_pointer_shift_minusone;
  logic             i_wr_rdy;
  logic             o_core_rst;
  logic             o_load_done;
  logic             o_load_error;
  logic [LOGD:0]    o_byte_count;

  int   errors = 0;
  int   checks = 0;
  int   rdy_mode = 0;     // 0 always ready, 1 random, 2 stall first write, 3 never
  int   stall_left = 0;
  wr_t  exp_q[$];
  logic [7:0] img[$];

  wasm_instr_loader #(
    .WIN_BYTES   (WIN),
    .LOG_WIN     (LOGW),
    .DEPTH_BYTES (DEPTH),
    .LOG_DEPTH   (LOGD)
  ) dut (
    .i_clk                          (i_clk),
    .i_rst                          (i_rst),
    .i_start                        (i_start),
    .i_byte                         (i_byte),
    .i_byte_vld                     (i_byte_vld),
    .i_byte_last                    (i_byte_last),
    .o_byte_rdy                     (o_byte_rdy),
    .o_we                           (o_we),
    .o_wr_data                      (o_wr_data),
    .o_write_pointer_shift_minusone (o_write_pointer_shift_minusone),
    .i_wr_rdy                       (i_wr_rdy),
    .o_core_rst                     (o_core_rst),
    .o_load_done                    (o_load_done),
    .o_load_error                   (o_load_error),
    .o_byte_count                   (o_byte_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_core_rst"}, o_core_rst, 1);
    check({tag, "_byte_rdy"}, o_byte_rdy, 0);
    check({tag, "_we"}, o_we, 0);
    check({tag, "_wr_data"}, o_wr_data, 0);
    check({tag, "_shift"}, o_write_pointer_shift_minusone, 0);
    check({tag, "_done"}, o_load_done, 0);
    check({tag, "_error"}, o_load_error, 0);
    check({tag, "_count"}, o_byte_count, 0);
  endtask

  // Memory-side ready generator.
  initial begin
    i_wr_rdy = 1'b1;
    forever begin
      @(negedge i_clk);
      case (rdy_mode)
        0: i_wr_rdy = 1'b1;
        1: i_wr_rdy = ($urandom_range(0, 2) != 0);
        2: begin
          if (o_we && stall_left > 0) begin
            i_wr_rdy = 1'b0;
            stall_left--;
          end else begin
            i_wr_rdy = 1'b1;
          end
        end
        default: i_wr_rdy = 1'b0;
      endcase
    end
  end

  // Monitor: samples just after the falling edge, when both DUT outputs and
  // the inputs for the coming rising edge are settled.
  initial begin
    logic             prev_we = 1'b0;
    logic             prev_xfer = 1'b0;
    logic [8*WIN-1:0] prev_data = '0;
    logic [LOGW-1:0]  prev_shift = '0;
    bit               done_due = 1'b0;
    wr_t              e;
    forever begin
      @(negedge i_clk);
      #1;
      if (i_rst) begin
        prev_we = 1'b0;
        prev_xfer = 1'b0;
        done_due = 1'b0;
      end else begin
        if (done_due) begin
          check("done_after_last_write", o_load_done, 1);
          check("core_rst_after_last_write", o_core_rst, 0);
          done_due = 1'b0;
        end
        if (o_we) begin
          check("byte_rdy_low_in_write", o_byte_rdy, 0);
          if (prev_we && !prev_xfer) begin
            check("held_wr_data", o_wr_data, prev_data);
            check("held_shift", o_write_pointer_shift_minusone, prev_shift);
          end
          if (i_wr_rdy) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_write: got data 0x%016h with no write pending", o_wr_data);
            end else begin
              e = exp_q.pop_front();
              $display("write data=0x%016h shift=%0d last=%0d", o_wr_data,
                       o_write_pointer_shift_minusone, e.last);
              check("wr_data", o_wr_data, e.data);
              check("wr_shift", o_write_pointer_shift_minusone, e.shift);
              done_due = e.last;
            end
          end
        end
        prev_we    = o_we;
        prev_xfer  = o_we && i_wr_rdy;
        prev_data  = o_wr_data;
        prev_shift = o_write_pointer_shift_minusone;
      end
    end
  end

  task automatic pulse_start();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    check("start_core_rst", o_core_rst, 1);
    check("start_done_clear", o_load_done, 0);
    check("start_error_clear", o_load_error, 0);
    check("start_count_clear", o_byte_count, 0);
    check("start_byte_rdy", o_byte_rdy, 1);
  endtask

  // Offer one byte until accepted or the loader aborts on overflow.
  task automatic drive_byte(input logic [7:0] b, input bit last, input bit rnd,
                            output bit aborted);
    aborted = 1'b0;
    @(negedge i_clk);
    i_byte = b;
    i_byte_vld = 1'b1;
    i_byte_last = last;
    for (int k = 0; k < 200; k++) begin
      if (o_byte_rdy) begin
        // A start pulse while filling must be ignored.
        if (rnd && $urandom_range(0, 7) == 0) i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_byte_vld = 1'b0;
        i_byte_last = 1'b0;
        i_start = 1'b0;
        return;
      end
      if (o_load_error) begin
        aborted = 1'b1;
        i_byte_vld = 1'b0;
        i_byte_last = 1'b0;
        return;
      end
      @(negedge i_clk);
    end
    i_byte_vld = 1'b0;
    i_byte_last = 1'b0;
    check("byte_accept_timeout", 0, 1);
  endtask

  // Load img[] as one image and check the outcome against the model.
  task automatic run_image(input bit rnd);
    int  len = img.size();
    int  acc = (len > DEPTH) ? DEPTH : len;
    bit  exp_err = (len > DEPTH);
    int  nw = exp_err ? acc / WIN : (acc + WIN - 1) / WIN;
    bit  ab;
    bit  ended = 1'b0;
    wr_t e;
    for (int w = 0; w < nw; w++) begin
      int n = ((acc - w * WIN) < WIN) ? (acc - w * WIN) : WIN;
      e.data = '0;
      for (int j = 0; j < n; j++) e.data[8*j +: 8] = img[w*WIN + j];
      e.shift = LOGW'(n - 1);
      e.last = !exp_err && (w == nw - 1);
      exp_q.push_back(e);
    end
    pulse_start();
    for (int i = 0; i < len; i++) begin
      drive_byte(img[i], (i == len - 1), rnd, ab);
      if (ab) break;
      if (rnd) begin
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          @(negedge i_clk);
          i_byte_last = $urandom_range(0, 1);  // last without valid: ignored
        end
        i_byte_last = 1'b0;
      end
    end
    for (int k = 0; k < 200; k++) begin
      @(negedge i_clk);
      if (o_load_done || o_load_error) begin
        ended = 1'b1;
        break;
      end
    end
    if (!ended) check("image_end_timeout", 0, 1);
    @(negedge i_clk);
    check("final_done", o_load_done, !exp_err);
    check("final_error", o_load_error, exp_err);
    check("final_core_rst", o_core_rst, exp_err);
    check("final_count", o_byte_count, acc);
    check("final_we", o_we, 0);
    check("writes_outstanding", exp_q.size(), 0);
    $display("image len=%0d count=%0d done=%0d error=%0d", len, o_byte_count,
             o_load_done, o_load_error);
    exp_q.delete();
  endtask

  initial begin
    bit ab;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_byte = '0;
    i_byte_vld = 1'b0;
    i_byte_last = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset_values("por");
    i_rst = 1'b0;

    // Single full window, last on 0x07.
    img.delete();
    for (int i = 0; i < 8; i++) img.push_back(8'(i));
    run_image(0);

    // Restart after completion: 11 bytes, full window then a 3-byte tail.
    img.delete();
    for (int i = 0; i < 11; i++) img.push_back(8'hA0 + 8'(i));
    run_image(0);

    // Memory stalls the first write for 5 cycles.
    rdy_mode = 2;
    stall_left = 5;
    img.delete();
    for (int i = 0; i < 11; i++) img.push_back(8'($urandom));
    run_image(0);
    rdy_mode = 0;

    // Exactly full memory, then one byte too many.
    img.delete();
    for (int i = 0; i < 16; i++) img.push_back(8'($urandom));
    run_image(0);
    img.delete();
    for (int i = 0; i < 17; i++) img.push_back(8'h30 + 8'(i));
    run_image(0);

    // Asynchronous reset after 3 bytes.
    pulse_start();
    for (int i = 0; i < 3; i++) drive_byte(8'h10 + 8'(i), 1'b0, 1'b0, ab);
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1 check_reset_values("rst_fill");
    @(negedge i_clk);
    i_rst = 1'b0;

    // Asynchronous reset while a write is pending.
    rdy_mode = 3;
    pulse_start();
    for (int i = 0; i < 8; i++) drive_byte(8'h60 + 8'(i), 1'b0, 1'b0, ab);
    @(negedge i_clk);
    check("we_pending_before_rst", o_we, 1);
    #2 i_rst = 1'b1;
    #1 check_reset_values("rst_write");
    @(negedge i_clk);
    i_rst = 1'b0;
    rdy_mode = 0;

    // One-byte image after reset.
    img.delete();
    img.push_back(8'h5C);
    run_image(0);

    // Randomized images, some overflowing.
    rdy_mode = 1;
    for (int t = 0; t < 20; t++) begin
      int len = $urandom_range(1, 18);
      img.delete();
      for (int i = 0; i < len; i++) img.push_back(8'($urandom));
      run_image(1);
    end
    rdy_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
